mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 139 +++++++++++++
 tb/tb_mem_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory stage of a 5-stage pipeline: issues data-memory requests, stalls until
// the access completes, resolves branch redirects and loads the writeback register.
module mem_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_M,
    input  logic [31:0]      PC_M,
    input  logic [31:0]      PC_branch_M,
    input  logic [31:0]      imm_M,
    input  logic [31:0]      rs2_rdata_M,
    input  logic [31:0]      alu_result_M,
    input  logic [4:0]       rd_waddr_M,
    input  logic             zero_M,
    input  logic             branch_M,
    input  logic             MemWrite_M,
    input  logic             jal_M,
    input  logic             jalr_M,
    input  logic             rd_wen_M,
    input  logic [1:0]       PMAItoReg_M,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [31:0]      dmem_addr,
    output logic [31:0]      dmem_wdata,
    input  logic             dmem_gnt,
    input  logic             dmem_rvalid,
    input  logic [31:0]      dmem_rdata,
    output logic             stall_M,
    output logic             pc_sel_M,
    output logic [31:0]      pc_target_M,
    output logic             valid_W,
    output logic             rd_wen_W,
    output logic [4:0]       rd_waddr_W,
    output logic [31:0]      rd_wdata_W,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic {
        S_IDLE,
        S_RSP
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic             w_is_load;
    logic             w_is_store;
    logic             w_mem_op;
    logic             w_complete;
    logic             w_taken;
    logic             w_advance;
    logic [31:0]      w_wb_data;

    logic             r_valid_W;
    logic             r_rd_wen_W;
    logic [4:0]       r_rd_waddr_W;
    logic [31:0]      r_rd_wdata_W;
    logic [CNT_W-1:0] r_stall_cnt;

    assign w_is_load  = (PMAItoReg_M == 2'b01) & ~MemWrite_M;
    assign w_is_store = MemWrite_M;
    assign w_mem_op   = MemWrite_M | (PMAItoReg_M == 2'b01);

    // Request fields come straight from the EX/M register, which is frozen while
    // stalled, so they stay stable until the grant arrives.
    assign dmem_addr  = alu_result_M;
    assign dmem_wdata = rs2_rdata_M;
    assign dmem_we    = MemWrite_M;

    // Stores finish on the grant; loads finish only on rvalid seen in RSP, so a
    // stray rvalid in IDLE never completes anything.
    assign w_complete = (r_state == S_IDLE & w_is_store & dmem_gnt)
                      | (r_state == S_RSP  & w_is_load  & dmem_rvalid);

    assign stall_M     = valid_M & w_mem_op & ~w_complete;
    assign w_taken     = (branch_M & zero_M) | jal_M | jalr_M;
    assign pc_sel_M    = valid_M & w_taken & ~stall_M;
    assign pc_target_M = jalr_M ? {alu_result_M[31:1], 1'b0} : PC_branch_M;
    assign w_advance   = valid_M & ~stall_M;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        w_state_nxt = r_state;
        dmem_req    = 1'b0;
        case (r_state)
            S_IDLE: begin
                dmem_req = valid_M & w_mem_op;
                if (dmem_req & w_is_load & dmem_gnt)
                    w_state_nxt = S_RSP;
            end
            S_RSP: begin
                if (dmem_rvalid)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_wb_data = alu_result_M;
        case (PMAItoReg_M)
            2'b00:   w_wb_data = alu_result_M;
            2'b01:   w_wb_data = dmem_rdata;
            2'b10:   w_wb_data = PC_M + 32'd4;
            default: w_wb_data = imm_M;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_valid_W    <= 1'b0;
            r_rd_wen_W   <= 1'b0;
            r_rd_waddr_W <= '0;
            r_rd_wdata_W <= '0;
            r_stall_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_valid_W  <= w_advance;
            r_rd_wen_W <= w_advance & rd_wen_M & (rd_waddr_M != 5'd0);
            if (w_advance) begin
                r_rd_waddr_W <= rd_waddr_M;
                r_rd_wdata_W <= w_wb_data;
            end
            if (stall_M && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign valid_W    = r_valid_W;
    assign rd_wen_W   = r_rd_wen_W;
    assign rd_waddr_W = r_rd_waddr_W;
    assign rd_wdata_W = r_rd_wdata_W;
    assign stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_mem_stage.sv
// Directed-vector bench for mem_stage: ALU, load, store, branch/jalr,
// x0 writes, reset mid-load and stall counter saturation.
module tb_mem_stage;

    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             valid_M;
    logic [31:0]      PC_M, PC_branch_M, imm_M, rs2_rdata_M, alu_result_M;
    logic [4:0]       rd_waddr_M;
    logic             zero_M, branch_M, MemWrite_M, jal_M, jalr_M, rd_wen_M;
    logic [1:0]       PMAItoReg_M;
    logic             dmem_req, dmem_we;
    logic [31:0]      dmem_addr, dmem_wdata;
    logic             dmem_gnt, dmem_rvalid;
    logic [31:0]      dmem_rdata;
    logic             stall_M, pc_sel_M;
    logic [31:0]      pc_target_M;
    logic             valid_W, rd_wen_W;
    logic [4:0]       rd_waddr_W;
    logic [31:0]      rd_wdata_W;
    logic [CNT_W-1:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_stage #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .valid_M(valid_M),
        .PC_M(PC_M), .PC_branch_M(PC_branch_M), .imm_M(imm_M),
        .rs2_rdata_M(rs2_rdata_M), .alu_result_M(alu_result_M),
        .rd_waddr_M(rd_waddr_M), .zero_M(zero_M), .branch_M(branch_M),
        .MemWrite_M(MemWrite_M), .jal_M(jal_M), .jalr_M(jalr_M),
        .rd_wen_M(rd_wen_M), .PMAItoReg_M(PMAItoReg_M),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
        .dmem_rdata(dmem_rdata), .stall_M(stall_M), .pc_sel_M(pc_sel_M),
        .pc_target_M(pc_target_M), .valid_W(valid_W), .rd_wen_W(rd_wen_W),
        .rd_waddr_W(rd_waddr_W), .rd_wdata_W(rd_wdata_W), .stall_cnt(stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Advance past the next rising edge; inputs driven and outputs sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_M = 0; PC_M = 0; PC_branch_M = 0; imm_M = 0; rs2_rdata_M = 0;
        alu_result_M = 0; rd_waddr_M = 0; zero_M = 0; branch_M = 0;
        MemWrite_M = 0; jal_M = 0; jalr_M = 0; rd_wen_M = 0; PMAItoReg_M = 2'b00;
        dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        step(); step();
        check("rst_valid_W", {31'd0, valid_W}, 32'd0);
        check("rst_rd_wen_W", {31'd0, rd_wen_W}, 32'd0);
        check("rst_rd_waddr_W", {27'd0, rd_waddr_W}, 32'd0);
        check("rst_rd_wdata_W", rd_wdata_W, 32'd0);
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        rst = 0;

        // ALU op writes 0x55 to x5 one edge later, never stalls
        valid_M = 1; alu_result_M = 32'h55; rd_waddr_M = 5; rd_wen_M = 1;
        #1;
        check("alu_stall", {31'd0, stall_M}, 32'd0);
        check("alu_req", {31'd0, dmem_req}, 32'd0);
        check("alu_pc_sel", {31'd0, pc_sel_M}, 32'd0);
        step();
        check("alu_valid_W", {31'd0, valid_W}, 32'd1);
        check("alu_waddr_W", {27'd0, rd_waddr_W}, 32'd5);
        check("alu_wdata_W", rd_wdata_W, 32'h55);
        check("alu_wen_W", {31'd0, rd_wen_W}, 32'd1);
        idle_inputs();
        step();
        check("bubble_valid_W", {31'd0, valid_W}, 32'd0);
        check("bubble_wen_W", {31'd0, rd_wen_W}, 32'd0);
        check("bubble_wdata_hold", rd_wdata_W, 32'h55);
        check("bubble_waddr_hold", {27'd0, rd_waddr_W}, 32'd5);

        // Load 0x100: grant at cycle 0, rvalid at cycle 3
        valid_M = 1; PMAItoReg_M = 2'b01; alu_result_M = 32'h100; rd_waddr_M = 7;
        rd_wen_M = 1; dmem_gnt = 1;
        #1;
        check("ld_req_c0", {31'd0, dmem_req}, 32'd1);
        check("ld_addr_c0", dmem_addr, 32'h100);
        check("ld_we_c0", {31'd0, dmem_we}, 32'd0);
        check("ld_stall_c0", {31'd0, stall_M}, 32'd1);
        step();
        dmem_gnt = 0;
        for (int c = 1; c <= 2; c++) begin
            #1;
            check($sformatf("ld_stall_c%0d", c), {31'd0, stall_M}, 32'd1);
            check($sformatf("ld_req_c%0d", c), {31'd0, dmem_req}, 32'd0);
            check($sformatf("ld_valid_W_c%0d", c), {31'd0, valid_W}, 32'd0);
            step();
        end
        dmem_rvalid = 1; dmem_rdata = 32'hDEADBEEF;
        #1;
        check("ld_stall_c3", {31'd0, stall_M}, 32'd0);
        step();
        check("ld_valid_W", {31'd0, valid_W}, 32'd1);
        check("ld_wdata_W", rd_wdata_W, 32'hDEADBEEF);
        check("ld_waddr_W", {27'd0, rd_waddr_W}, 32'd7);
        check("ld_stall_cnt", 32'(stall_cnt), 32'd3);
        idle_inputs();

        // Store 0x200 <- 0x12345678 with grant withheld two cycles
        valid_M = 1; MemWrite_M = 1; alu_result_M = 32'h200; rs2_rdata_M = 32'h12345678;
        for (int c = 0; c < 2; c++) begin
            #1;
            check($sformatf("st_req_c%0d", c), {31'd0, dmem_req}, 32'd1);
            check($sformatf("st_we_c%0d", c), {31'd0, dmem_we}, 32'd1);
            check($sformatf("st_addr_c%0d", c), dmem_addr, 32'h200);
            check($sformatf("st_wdata_c%0d", c), dmem_wdata, 32'h12345678);
            check($sformatf("st_stall_c%0d", c), {31'd0, stall_M}, 32'd1);
            step();
        end
        dmem_gnt = 1;
        #1;
        check("st_stall_gnt", {31'd0, stall_M}, 32'd0);
        step();
        check("st_valid_W", {31'd0, valid_W}, 32'd1);
        check("st_wen_W", {31'd0, rd_wen_W}, 32'd0);
        check("st_stall_cnt", 32'(stall_cnt), 32'd5);
        idle_inputs();

        // beq taken / not taken
        valid_M = 1; branch_M = 1; zero_M = 1; PC_branch_M = 32'h40;
        #1;
        check("beq_pc_sel", {31'd0, pc_sel_M}, 32'd1);
        check("beq_target", pc_target_M, 32'h40);
        zero_M = 0;
        #1;
        check("beq_nt_pc_sel", {31'd0, pc_sel_M}, 32'd0);
        step();
        idle_inputs();

        // jalr: target clears bit 0, link value PC+4
        valid_M = 1; jalr_M = 1; alu_result_M = 32'h83; PC_M = 32'h10;
        rd_waddr_M = 1; rd_wen_M = 1; PMAItoReg_M = 2'b10; PC_branch_M = 32'h999;
        #1;
        check("jalr_pc_sel", {31'd0, pc_sel_M}, 32'd1);
        check("jalr_target", pc_target_M, 32'h82);
        step();
        check("jalr_wdata_W", rd_wdata_W, 32'h14);
        check("jalr_wen_W", {31'd0, rd_wen_W}, 32'd1);
        idle_inputs();

        // Write to x0 is suppressed; imm select path
        valid_M = 1; rd_waddr_M = 0; rd_wen_M = 1; PMAItoReg_M = 2'b11; imm_M = 32'hABCD;
        step();
        check("x0_wen_W", {31'd0, rd_wen_W}, 32'd0);
        check("x0_valid_W", {31'd0, valid_W}, 32'd1);
        check("imm_wdata_W", rd_wdata_W, 32'hABCD);
        idle_inputs();

        // rvalid in IDLE cannot complete a load that is only now being granted
        valid_M = 1; PMAItoReg_M = 2'b01; alu_result_M = 32'h300; rd_waddr_M = 3;
        rd_wen_M = 1; dmem_gnt = 1; dmem_rvalid = 1; dmem_rdata = 32'h1111;
        #1;
        check("idle_rvalid_stall", {31'd0, stall_M}, 32'd1);
        step();
        dmem_gnt = 0; dmem_rdata = 32'h2222;
        #1;
        check("rsp_rvalid_stall", {31'd0, stall_M}, 32'd0);
        step();
        check("rsp_ld_wdata_W", rd_wdata_W, 32'h2222);
        idle_inputs();

        // Reset while in RSP abandons the load
        valid_M = 1; PMAItoReg_M = 2'b01; alu_result_M = 32'h400; rd_waddr_M = 9;
        rd_wen_M = 1; dmem_gnt = 1;
        step();
        dmem_gnt = 0; rst = 1;
        step();
        rst = 0; idle_inputs(); dmem_rvalid = 1; dmem_rdata = 32'h5555;
        step();
        check("rstrsp_valid_W", {31'd0, valid_W}, 32'd0);
        check("rstrsp_wdata_W", rd_wdata_W, 32'd0);
        check("rstrsp_stall_cnt", 32'(stall_cnt), 32'd0);
        dmem_rvalid = 0; valid_M = 1; PMAItoReg_M = 2'b01;
        #1;
        check("rstrsp_idle_req", {31'd0, dmem_req}, 32'd1);
        idle_inputs();
        rst = 1;
        step();
        rst = 0;

        // Saturation: store without grant for 2^CNT_W+2 cycles
        valid_M = 1; MemWrite_M = 1; alu_result_M = 32'h500;
        for (int c = 0; c < (1 << CNT_W) + 2; c++) step();
        check("sat_stall_cnt", 32'(stall_cnt), 32'd31);
        check("sat_valid_W", {31'd0, valid_W}, 32'd0);
        idle_inputs();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
